pokey_serin: RTL

Serial input (receive) shifter for the POKEY core: the receive-side counterpart of the serial output shift register. Deserialises an asynchronous 8N1 stream on the SIO data-in pin, LSB first, into a SERIN holding register. Flags data-ready, framing error and overrun for the SKSTAT/IRQST logic. Bit timing comes from a half-bit tick supplied by the audio channel timer block.

---
 rtl/pokey_serin.sv | 117 +++++++++++
 1 files changed

// File: rtl/pokey_serin.sv
// POKEY serial input shifter: deserialises an 8N1 stream on sin into SERIN.
// Raises data-ready, framing-error and overrun flags; bit timing comes from a half-bit tick.
module pokey_serin #(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 R,
   input  logic                 enn,
   input  logic                 half_tick,
   input  logic                 sin,
   input  logic                 rd,
   input  logic                 skres,
   output logic [DATA_BITS-1:0] serin_data,
   output logic                 data_ready,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int CNT_W = $clog2(DATA_BITS + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_e;

   rxState_e               state;
   logic [SYNC_STAGES-1:0] syncReg;
   logic [SYNC_STAGES:0]   syncNext;
   logic                   ss;
   logic [DATA_BITS-1:0]   shiftReg;
   logic [CNT_W-1:0]       bitCnt;
   logic                   phase;
   logic                   armed;

   // syncReg[0] is the newest sample, syncReg[SYNC_STAGES-1] the settled one
   assign syncNext = {syncReg, sin};
   assign ss       = syncReg[SYNC_STAGES-1];
   assign busy     = (state != IDLE);

   always_ff @(negedge clk) begin
      if (R) begin
         state       <= IDLE;
         syncReg     <= '1;
         shiftReg    <= '0;
         bitCnt      <= '0;
         phase       <= 1'b0;
         armed       <= 1'b0;
         serin_data  <= '0;
         data_ready  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else if (enn) begin
         syncReg <= syncNext[SYNC_STAGES-1:0];

         // NOTE: the clears below are overridden by the later stop-bit sets in
         // this block, because the last non-blocking assignment to a reg wins.
         if (rd) data_ready <= 1'b0;
         if (skres) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (ss) begin
                  armed <= 1'b1;
               end else if (armed) begin
                  state  <= START;
                  phase  <= 1'b0;
                  bitCnt <= '0;
               end
            end

            START: begin
               if (half_tick) begin
                  if (ss) begin
                     state <= IDLE;
                  end else begin
                     state <= DATA;
                     phase <= 1'b0;
                  end
               end
            end

            DATA: begin
               if (half_tick) begin
                  phase <= ~phase;
                  if (phase) begin
                     shiftReg <= {ss, shiftReg[DATA_BITS-1:1]};
                     bitCnt   <= bitCnt + 1'b1;
                     if (bitCnt == CNT_W'(DATA_BITS - 1)) state <= STOP;
                  end
               end
            end

            STOP: begin
               if (half_tick) begin
                  phase <= ~phase;
                  if (phase) begin
                     serin_data <= shiftReg;
                     data_ready <= 1'b1;
                     if (!ss) begin
                        frame_err <= 1'b1;
                        armed     <= 1'b0;
                     end
                     // a read on this very edge acknowledges the previous byte
                     if (data_ready && !rd) overrun_err <= 1'b1;
                     state <= IDLE;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
